// File: rtl/window_pkg.sv
// Shared constants, FSM encoding and width helpers for the window line buffer.
package window_pkg;

    localparam int BORDER_DROP      = 0;
    localparam int BORDER_REPLICATE = 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int X_W(input int max_width);
        return (max_width > 1) ? $clog2(max_width) : 1;
    endfunction

    function automatic int Y_W(input int ksize);
        return (ksize > 1) ? $clog2(ksize) : 1;
    endfunction

    function automatic bit ksize_ok(input int ksize);
        return (ksize >= 3) && (ksize <= 7) && (ksize % 2 == 1);
    endfunction

endpackage

// File: rtl/simple_dual_port_ram.sv
// One write port, one read port with a registered (1-cycle) read.
module simple_dual_port_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/window_line_buffer.sv
// K-row line buffer: raster pixels in, vertical KSIZE-pixel columns out two
// cycles later, with DROP or REPLICATE handling of the top rows of a frame.
module window_line_buffer
    import window_pkg::*;
#(
    parameter int PIX_WIDTH = 16,
    parameter int MAX_WIDTH = 1024,
    parameter int KSIZE     = 3,
    parameter int BORDER    = BORDER_DROP
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic                           sof,
    input  logic [PIX_WIDTH-1:0]           pixel_in,
    input  logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width,
    output logic                           col_valid,
    output logic [KSIZE*PIX_WIDTH-1:0]     col_out,
    output logic [X_W(MAX_WIDTH)-1:0]      col_x,
    output logic                           col_sol,
    output logic                           col_eol
);

    localparam int CW = $clog2(MAX_WIDTH+1);
    localparam int XW = X_W(MAX_WIDTH);
    localparam int YW = Y_W(KSIZE);
    localparam logic [YW-1:0] Y_MAX = YW'(KSIZE-1);
    localparam logic [CW-1:0] W_MAX = CW'(MAX_WIDTH);

    if (!ksize_ok(KSIZE)) begin : g_bad_ksize
        $error("window_line_buffer: KSIZE must be odd and within 3..7");
    end

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    state_t state, state_nxt;
    logic   start, accept;

    assign start  = valid_in && sof;
    assign accept = valid_in && (sof || state == ST_RUN);

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) state_nxt = ST_RUN;
    end

    // A sof pixel is (0,0) of a fresh frame, so it bypasses the live counters.
    logic [CW-1:0] width, cfg_clamped, cur_w;
    logic [XW-1:0] x, cur_x;
    logic [YW-1:0] y, cur_y;
    logic          last;

    assign cfg_clamped = (cfg_width == '0 || cfg_width > W_MAX) ? W_MAX : cfg_width;
    assign cur_w = start ? cfg_clamped : width;
    assign cur_x = start ? '0 : x;
    assign cur_y = start ? '0 : y;
    assign last  = (CW'(cur_x) == cur_w - CW'(1));

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            x     <= '0;
            y     <= '0;
            width <= W_MAX;
        end else if (accept) begin
            width <= cur_w;
            x     <= last ? '0 : cur_x + XW'(1);
            y     <= (last && cur_y != Y_MAX) ? cur_y + YW'(1) : cur_y;
        end
    end

    // vld_pipe[0]: RAM read stage; vld_pipe[1]: output register.
    logic [1:0]           vld_pipe;
    logic [PIX_WIDTH-1:0] s1_pix;
    logic [XW-1:0]        s1_x;
    logic [YW-1:0]        s1_y;
    logic                 s1_sol, s1_eol, s1_emit;

    assign s1_emit = (BORDER == BORDER_REPLICATE) || (s1_y == Y_MAX);

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            vld_pipe <= '0;
            s1_pix   <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_sol   <= 1'b0;
            s1_eol   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[0] && s1_emit, accept};
            if (accept) begin
                s1_pix <= pixel_in;
                s1_x   <= cur_x;
                s1_y   <= cur_y;
                s1_sol <= (cur_x == '0);
                s1_eol <= last;
            end
        end
    end

    // Rows shift one RAM deeper on write-back, one cycle after the read.
    logic [KSIZE-2:0][PIX_WIDTH-1:0] rd_row;
    logic [KSIZE-1:0][PIX_WIDTH-1:0] raw, col_nxt;

    for (genvar k = 0; k < KSIZE-1; k++) begin : g_line
        logic [PIX_WIDTH-1:0] wr_data;
        if (k == 0) begin : g_head
            assign wr_data = s1_pix;
        end else begin : g_chain
            assign wr_data = rd_row[k-1];
        end
        simple_dual_port_ram #(
            .DATA_W (PIX_WIDTH),
            .DEPTH  (MAX_WIDTH),
            .ADDR_W (XW)
        ) u_ram (
            .clk   (clk),
            .we    (vld_pipe[0]),
            .waddr (s1_x),
            .wdata (wr_data),
            .re    (accept),
            .raddr (cur_x),
            .rdata (rd_row[k])
        );
    end

    assign raw = {rd_row, s1_pix};

    // Rows older than the frame's row 0 take row 0 (slot y) instead.
    for (genvar i = 0; i < KSIZE; i++) begin : g_slot
        if (BORDER == BORDER_REPLICATE && i > 0) begin : g_rep
            assign col_nxt[i] = (YW'(i) > s1_y) ? raw[s1_y] : raw[i];
        end else begin : g_raw
            assign col_nxt[i] = raw[i];
        end
    end

    assign col_valid = vld_pipe[1];

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            col_out <= '0;
            col_x   <= '0;
            col_sol <= 1'b0;
            col_eol <= 1'b0;
        end else if (vld_pipe[0] && s1_emit) begin
            col_out <= col_nxt;
            col_x   <= s1_x;
            col_sol <= s1_sol;
            col_eol <= s1_eol;
        end
    end

endmodule

// File: tb/tb_window_line_buffer.sv
// Three configurations (K3 DROP, K3 REPLICATE, K5 DROP/16) share one stream and
// are scored against a frame-image model of which rows a column must contain.
module tb_window_line_buffer;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0, sof = 1'b0;
    logic [PW-1:0] pixel_in = '0;
    logic [10:0]   cfg_a = '0;
    logic [4:0]    cfg_b = '0;

    logic        v0, v1, v2, sol0, sol1, sol2, eol0, eol1, eol2;
    logic [47:0] c0, c1;
    logic [79:0] c2;
    logic [9:0]  x0, x1;
    logic [3:0]  x2;

    always #5 clk = ~clk;

    window_line_buffer #(.PIX_WIDTH(PW), .MAX_WIDTH(1024), .KSIZE(3), .BORDER(0)) u_drop (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .pixel_in(pixel_in),
        .cfg_width(cfg_a), .col_valid(v0), .col_out(c0), .col_x(x0), .col_sol(sol0), .col_eol(eol0));

    window_line_buffer #(.PIX_WIDTH(PW), .MAX_WIDTH(1024), .KSIZE(3), .BORDER(1)) u_rep (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .pixel_in(pixel_in),
        .cfg_width(cfg_a), .col_valid(v1), .col_out(c1), .col_x(x1), .col_sol(sol1), .col_eol(eol1));

    window_line_buffer #(.PIX_WIDTH(PW), .MAX_WIDTH(16), .KSIZE(5), .BORDER(0)) u_k5 (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .sof(sof), .pixel_in(pixel_in),
        .cfg_width(cfg_b), .col_valid(v2), .col_out(c2), .col_x(x2), .col_sol(sol2), .col_eol(eol2));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    typedef struct packed {
        int          due;
        logic [79:0] col;
        int          x;
        logic        sol;
        logic        eol;
    } exp_t;

    int   KS [3] = '{3, 3, 5};
    bit   REP[3] = '{0, 1, 0};
    int   MW [3] = '{1024, 1024, 16};
    bit   run[3];
    int   mx[3], mr[3], mw[3];
    logic [PW-1:0] img [3][8][1024];
    exp_t q [3][$];
    int   ncol[3];
    bit   grab[3];
    logic [79:0] first[3];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slot i of a column is the frame's row (r-i) at the same x; REPLICATE
    // substitutes row 0 for rows above the frame, DROP waits for full depth.
    task automatic model_pix(input int n, input bit s, input logic [PW-1:0] p, input int cfg);
        exp_t e;
        if (s) begin
            run[n] = 1'b1;
            mw[n]  = (cfg == 0 || cfg > MW[n]) ? MW[n] : cfg;
            mx[n]  = 0;
            mr[n]  = 0;
        end else if (!run[n]) begin
            return;
        end
        img[n][mr[n] % 8][mx[n]] = p;
        if (REP[n] || mr[n] >= KS[n] - 1) begin
            e.due = cyc + 2;
            e.col = '0;
            e.x   = mx[n];
            e.sol = (mx[n] == 0);
            e.eol = (mx[n] == mw[n] - 1);
            for (int i = 0; i < KS[n]; i++) begin
                int rr;
                rr = mr[n] - i;
                if (rr < 0) rr = 0;
                e.col[i*16 +: 16] = img[n][rr % 8][mx[n]];
            end
            q[n].push_back(e);
        end
        if (mx[n] == mw[n] - 1) begin
            mx[n] = 0;
            mr[n]++;
        end else begin
            mx[n]++;
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [PW-1:0] p);
        @(posedge clk);
        #1;
        valid_in = v;
        sof      = s;
        pixel_in = p;
        if (v) for (int n = 0; n < 3; n++) model_pix(n, s, p, (n == 2) ? int'(cfg_b) : int'(cfg_a));
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    // ramp pixels are 16*row+x of the frame starting at the latest sof.
    task automatic frame(input int npix, input int w, input int gap_pct, input int sof_at, input bit ramp);
        int j;
        for (int i = 0; i < npix; i++) begin
            while ($urandom_range(99) < gap_pct) drive(1'b0, 1'b0, '0);
            j = (sof_at >= 0 && i >= sof_at) ? i - sof_at : i;
            drive(1'b1, (i == 0) || (i == sof_at), ramp ? PW'(16 * (j / w) + j % w) : PW'($urandom));
        end
        idle(4);
    endtask

    always @(negedge clk) begin
        logic vv, ss, ee;
        logic [79:0] cc;
        int xx;
        bit ev;
        exp_t e;
        for (int n = 0; n < 3; n++) begin
            case (n)
                0:       begin vv = v0; cc = 80'(c0); xx = int'(x0); ss = sol0; ee = eol0; end
                1:       begin vv = v1; cc = 80'(c1); xx = int'(x1); ss = sol1; ee = eol1; end
                default: begin vv = v2; cc = c2;      xx = int'(x2); ss = sol2; ee = eol2; end
            endcase
            ev = (q[n].size() > 0) && (q[n][0].due == cyc);
            chk($sformatf("col_valid[%0d]@%0d", n, cyc), 80'(vv), 80'(ev));
            if (ev) begin
                e = q[n].pop_front();
                chk($sformatf("col_out[%0d]", n), cc, e.col);
                chk($sformatf("col_x[%0d]", n), 80'(xx), 80'(e.x));
                chk($sformatf("sol_eol[%0d]", n), 80'({ss, ee}), 80'({e.sol, e.eol}));
            end
            if (vv) begin
                ncol[n]++;
                if (grab[n]) begin
                    first[n] = cc;
                    grab[n]  = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b[3];
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 80'({v0, v1, v2}), '0);
        chk("rst_col", 80'(c0) | 80'(c1) | c2, '0);
        chk("rst_x_sol_eol", 80'({x0, x1, x2, sol0, sol1, sol2, eol0, eol1, eol2}), '0);
        rst_n = 1'b1;
        idle(4);

        // pixels without a sof after reset are ignored
        cfg_a = 8; cfg_b = 8;
        b = ncol;
        repeat (12) drive(1'($urandom_range(1)), 1'b0, PW'($urandom));
        idle(4);
        chk("pre_sof_cols", 80'(ncol[0] + ncol[1] + ncol[2] - b[0] - b[1] - b[2]), '0);

        for (int pass = 0; pass < 2; pass++) begin
            grab = '{1'b1, 1'b1, 1'b1};
            b = ncol;
            frame(32, 8, pass * 50, -1, 1'b1);
            chk("ramp_drop_count", 80'(ncol[0] - b[0]), 80'(16));
            chk("ramp_rep_count", 80'(ncol[1] - b[1]), 80'(32));
            chk("ramp_k5_count", 80'(ncol[2] - b[2]), 80'(0));
            chk("ramp_drop_first", first[0], 80'h0000_0010_0020);
            chk("ramp_rep_first", first[1], 80'h0000_0000_0000);
        end

        cfg_a = 0; cfg_b = 0;
        grab = '{1'b1, 1'b1, 1'b1};
        b = ncol;
        frame(96, 16, 0, -1, 1'b1);
        chk("clamp_drop_count", 80'(ncol[0] - b[0]), 80'(0));
        chk("clamp_rep_count", 80'(ncol[1] - b[1]), 80'(96));
        chk("clamp_k5_count", 80'(ncol[2] - b[2]), 80'(32));
        chk("clamp_k5_first", first[2], 80'h0000_0010_0020_0030_0040);

        // sof again at (5,1) of a width-8 frame
        cfg_a = 8; cfg_b = 8;
        b = ncol;
        frame(37, 8, 0, 13, 1'b1);
        chk("resof_drop_count", 80'(ncol[0] - b[0]), 80'(8));
        chk("resof_rep_count", 80'(ncol[1] - b[1]), 80'(37));
        chk("resof_k5_count", 80'(ncol[2] - b[2]), 80'(0));

        for (int f = 0; f < 6; f++) begin
            cfg_a = 11'($urandom_range(3, 20));
            cfg_b = 5'($urandom_range(0, 31));
            if (cfg_b != 0 && cfg_b < 5) cfg_b = 5;
            frame($urandom_range(60, 200), 1, 30, $urandom_range(1) ? $urandom_range(20, 150) : -1, 1'b0);
        end

        // asynchronous reset in the middle of a line
        cfg_a = 7; cfg_b = 9;
        drive(1'b1, 1'b1, PW'($urandom));
        repeat (20) drive(1'b1, 1'b0, PW'($urandom));
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        valid_in = 1'b0;
        for (int n = 0; n < 3; n++) begin
            q[n].delete();
            run[n] = 1'b0;
        end
        #1;
        chk("arst_valid", 80'({v0, v1, v2}), '0);
        chk("arst_col", 80'(c0) | 80'(c1) | c2, '0);
        chk("arst_x_sol_eol", 80'({x0, x1, x2, sol0, sol1, sol2, eol0, eol1, eol2}), '0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        b = ncol;
        repeat (6) drive(1'b1, 1'b0, PW'($urandom));
        idle(3);
        chk("post_rst_no_cols", 80'(ncol[0] + ncol[1] + ncol[2] - b[0] - b[1] - b[2]), '0);
        frame(80, 1, 30, -1, 1'b0);
        idle(4);
        for (int n = 0; n < 3; n++) chk($sformatf("drained[%0d]", n), 80'(q[n].size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
